ram_loader: RTL and testbench

//   Writer-side counterpart to the monitor/ROM read path. Takes a framed byte

---
 rtl/ram_loader_pkg.sv | 25 ++
 rtl/ram_loader_timeout.sv | 34 +++
 rtl/ram_loader.sv | 143 ++++++++++++++
 tb/tb_ram_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the UART-to-RAM frame loader: FSM state encoding,
// default sync marker and the frame length width.
package ram_loader_pkg;

  // Frame fields arrive in this order; CHECK exists only with checksums enabled.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_LEN_HI  = 3'd3,
    S_LEN_LO  = 3'd4,
    S_DATA    = 3'd5,
    S_CHECK   = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_WIDTH         = 16;

  // Bytes from ADDR_HI through the last data byte feed the running checksum.
  function automatic logic is_summed(state_t s);
    return (s == S_ADDR_HI) || (s == S_ADDR_LO) || (s == S_LEN_HI) ||
           (s == S_LEN_LO)  || (s == S_DATA);
  endfunction

endpackage

// File: rtl/ram_loader_timeout.sv
// Inter-byte watchdog: reloads to CYCLES on load, counts down while enabled,
// and flags the cycle whose edge would complete CYCLES idle cycles.
// CYCLES == 0 disables the watchdog entirely.
module ram_loader_timeout #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (CYCLES == 0) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] count;

  // Down-counter: reload has priority over counting.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CYCLES);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // The final idle cycle is the one that starts with a count of one.
  assign expired = (CYCLES != 0) && en && (count == W'(1));

endmodule

// File: rtl/ram_loader.sv
// ram_loader: receives SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN data bytes
// (and a trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined) from
// the UART receiver and writes the data bytes into RAM. busy holds the CPU
// off the bus for the duration of a frame.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned ADDR_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CHECK;
`else
  localparam state_t END_STATE = S_IDLE;
`endif

  state_t                state, next_state;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  sync_hit, data_wr, last_data, len_zero;
  logic                  good_end, bad_end;
  logic                  timeout_en, timeout_expired;

  assign sync_hit  = (state == S_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  assign data_wr   = (state == S_DATA) && rx_valid;
  assign last_data = data_wr && (remaining == LEN_WIDTH'(1));
  assign len_zero  = (state == S_LEN_LO) && rx_valid &&
                     ({remaining[LEN_WIDTH-1:8], rx_data} == '0);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk;
  logic       chk_in;

  assign chk_in   = (state == S_CHECK) && rx_valid;
  assign good_end = chk_in && (rx_data == chk);
  assign bad_end  = chk_in && (rx_data != chk);

  // Running XOR of every byte from ADDR_HI to the last data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk <= '0;
    end else if (sync_hit) begin
      chk <= '0;
    end else if (rx_valid && is_summed(state)) begin
      chk <= chk ^ rx_data;
    end
  end
`else
  assign good_end = len_zero || last_data;
  assign bad_end  = 1'b0;
`endif

  assign timeout_en = busy && !rx_valid;

  ram_loader_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (rx_valid),
    .en     (timeout_en),
    .expired(timeout_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: advance one field per accepted byte; watchdog aborts.
  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (sync_hit) next_state = S_ADDR_HI;
      S_ADDR_HI: if (rx_valid) next_state = S_ADDR_LO;
      S_ADDR_LO: if (rx_valid) next_state = S_LEN_HI;
      S_LEN_HI:  if (rx_valid) next_state = S_LEN_LO;
      S_LEN_LO:  if (rx_valid) next_state = len_zero ? END_STATE : S_DATA;
      S_DATA:    if (last_data) next_state = END_STATE;
      S_CHECK:   if (rx_valid) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (timeout_expired) next_state = S_IDLE;
  end

  // Output decode: a frame is in progress whenever the FSM is out of IDLE.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Header capture, write port, completion pulse and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hi   <= '0;
      next_addr <= '0;
      remaining <= '0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_we    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      ram_we <= data_wr;
      done   <= good_end;

      if (sync_hit) error <= 1'b0;
      else if (timeout_expired || bad_end) error <= 1'b1;

      if (rx_valid) begin
        case (state)
          S_ADDR_HI: addr_hi <= rx_data;
          S_ADDR_LO: next_addr <= ADDR_WIDTH'({addr_hi, rx_data});
          S_LEN_HI:  remaining[LEN_WIDTH-1:8] <= rx_data;
          S_LEN_LO:  remaining <= {remaining[LEN_WIDTH-1:8], rx_data};
          S_DATA: begin
            ram_addr  <= next_addr;
            ram_dout  <= rx_data;
            next_addr <= next_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader, built with TIMEOUT_CYCLES=100. Handles both
// the default build and LOADER_CHECKSUM_EN (trailing CHK byte).
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_we, busy, done, error;

  int checks = 0;
  int errors = 0;
  logic done_seen;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  ram_loader #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100),
    .ADDR_WIDTH    (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .ram_we  (ram_we),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [7:0] d, input logic we,
                              input logic [15:0] addr, input logic [7:0] dout,
                              input logic b, input logic dn, input logic er);
    vecs.push_back('{v: v, d: d, we: we, addr: addr, dout: dout, busy: b, done: dn, err: er});
  endfunction

  // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    done_seen = done_seen | done;
  endtask

  task automatic step_check(input string tag, input logic v, input logic [7:0] d,
                            input logic we, input logic [15:0] addr, input logic [7:0] dout,
                            input logic b, input logic dn, input logic er);
    drive(v, d);
    check({tag, " ram_we"}, 32'(ram_we), 32'(we));
    check({tag, " busy"},   32'(busy),   32'(b));
    check({tag, " done"},   32'(done),   32'(dn));
    check({tag, " error"},  32'(error),  32'(er));
    if (we) begin
      check({tag, " ram_addr"}, 32'(ram_addr), 32'(addr));
      check({tag, " ram_dout"}, 32'(ram_dout), 32'(dout));
    end
  endtask

  initial begin
    done_seen = 1'b0;

    // Ignored bytes in IDLE, then a basic two-byte frame.
    add(1, 8'h00, 0, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0, 0);
    add(1, 8'h7E, 0, 0, 0, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 1, 0, 0);
    add(1, 8'h03, 0, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0, 0);
    add(1, 8'h02, 0, 0, 0, 1, 0, 0);
    add(1, 8'h11, 1, 16'h0300, 8'h11, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    add(1, 8'h22, 1, 16'h0301, 8'h22, 1, 0, 0);
    add(1, 8'h32, 0, 0, 0, 0, 1, 0);
`else
    add(1, 8'h22, 1, 16'h0301, 8'h22, 0, 1, 0);
`endif
    add(0, 8'h00, 0, 0, 0, 0, 0, 0);
    // Address wrap at the top of the RAM.
    add(1, 8'hA5, 0, 0, 0, 1, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 1, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0, 0);
    add(1, 8'h02, 0, 0, 0, 1, 0, 0);
    add(1, 8'hAA, 1, 16'hFFFF, 8'hAA, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    add(1, 8'hBB, 1, 16'h0000, 8'hBB, 1, 0, 0);
    add(1, 8'h13, 0, 0, 0, 0, 1, 0);
`else
    add(1, 8'hBB, 1, 16'h0000, 8'hBB, 0, 1, 0);
`endif
    // Back-to-back zero-length frame.
    add(1, 8'hA5, 0, 0, 0, 1, 0, 0);
    add(1, 8'h12, 0, 0, 0, 1, 0, 0);
    add(1, 8'h34, 0, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    add(1, 8'h00, 0, 0, 0, 1, 0, 0);
    add(1, 8'h26, 0, 0, 0, 0, 1, 0);
`else
    add(1, 8'h00, 0, 0, 0, 0, 1, 0);
`endif
    add(0, 8'h00, 0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset ram_addr", 32'(ram_addr), 32'h0);
    check("reset ram_dout", 32'(ram_dout), 32'h0);
    check("reset ram_we",   32'(ram_we),   32'h0);
    check("reset busy",     32'(busy),     32'h0);
    check("reset done",     32'(done),     32'h0);
    check("reset error",    32'(error),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step_check($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].we, vecs[i].addr,
                 vecs[i].dout, vecs[i].busy, vecs[i].done, vecs[i].err);
    end

    // Timeout after ADDR_LO: still busy after 99 idle cycles, aborted on the 100th.
    step_check("to sync", 1, 8'hA5, 0, 0, 0, 1, 0, 0);
    step_check("to ahi",  1, 8'h01, 0, 0, 0, 1, 0, 0);
    step_check("to alo",  1, 8'h00, 0, 0, 0, 1, 0, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 99; i++) drive(0, 8'h00);
    check("to busy at 99", 32'(busy), 32'h1);
    check("to error at 99", 32'(error), 32'h0);
    drive(0, 8'h00);
    check("to busy at 100", 32'(busy), 32'h0);
    check("to error at 100", 32'(error), 32'h1);
    check("to no done", 32'(done_seen), 32'h0);
    step_check("to idle keeps error", 0, 8'h00, 0, 0, 0, 0, 0, 1);
    step_check("to resync clears", 1, 8'hA5, 0, 0, 0, 1, 0, 0);
    // A byte on the expiry cycle wins over the abort.
    for (int i = 0; i < 99; i++) drive(0, 8'h00);
    step_check("to byte wins", 1, 8'h05, 0, 0, 0, 1, 0, 0);
    step_check("to alo2", 1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("to lhi2", 1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("to llo2", 1, 8'h01, 0, 0, 0, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    step_check("to data2", 1, 8'h5A, 1, 16'h0500, 8'h5A, 1, 0, 0);
    step_check("to chk2",  1, 8'h5E, 0, 0, 0, 0, 1, 0);

    // Wrong checksum: both writes happen, then error without done.
    step_check("bad sync", 1, 8'hA5, 0, 0, 0, 1, 0, 0);
    step_check("bad ahi",  1, 8'h02, 0, 0, 0, 1, 0, 0);
    step_check("bad alo",  1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("bad lhi",  1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("bad llo",  1, 8'h02, 0, 0, 0, 1, 0, 0);
    step_check("bad d0",   1, 8'hC1, 1, 16'h0200, 8'hC1, 1, 0, 0);
    step_check("bad d1",   1, 8'hC2, 1, 16'h0201, 8'hC2, 1, 0, 0);
    step_check("bad chk",  1, 8'h00, 0, 0, 0, 0, 0, 1);
    step_check("bad after", 0, 8'h00, 0, 0, 0, 0, 0, 1);
`else
    step_check("to data2", 1, 8'h5A, 1, 16'h0500, 8'h5A, 0, 1, 0);
`endif

    // Reset in the middle of DATA while a write strobe is on the port.
    step_check("rst sync", 1, 8'hA5, 0, 0, 0, 1, 0, 0);
    step_check("rst ahi",  1, 8'h04, 0, 0, 0, 1, 0, 0);
    step_check("rst alo",  1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("rst lhi",  1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("rst llo",  1, 8'h03, 0, 0, 0, 1, 0, 0);
    step_check("rst d0",   1, 8'hD1, 1, 16'h0400, 8'hD1, 1, 0, 0);
    #1;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst ram_we",   32'(ram_we),   32'h0);
    check("midrst busy",     32'(busy),     32'h0);
    check("midrst ram_addr", 32'(ram_addr), 32'h0);
    check("midrst ram_dout", 32'(ram_dout), 32'h0);
    check("midrst done",     32'(done),     32'h0);
    check("midrst error",    32'(error),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step_check("fresh idle", 0, 8'h00, 0, 0, 0, 0, 0, 0);
    step_check("fresh sync", 1, 8'hA5, 0, 0, 0, 1, 0, 0);
    step_check("fresh ahi",  1, 8'h06, 0, 0, 0, 1, 0, 0);
    step_check("fresh alo",  1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("fresh lhi",  1, 8'h00, 0, 0, 0, 1, 0, 0);
    step_check("fresh llo",  1, 8'h01, 0, 0, 0, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    step_check("fresh d0",   1, 8'hE1, 1, 16'h0600, 8'hE1, 1, 0, 0);
    step_check("fresh chk",  1, 8'hE6, 0, 0, 0, 0, 1, 0);
`else
    step_check("fresh d0",   1, 8'hE1, 1, 16'h0600, 8'hE1, 0, 1, 0);
`endif
    step_check("fresh end", 0, 8'h00, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
